// File: rtl/renderer_rect_sequencer.sv
// rtl/renderer_rect_sequencer.sv - splits one rectangle fill into per-line fill engine jobs
// Optional clipping of x2/y2 to the screen edge: define RENDERER_RECT_SEQ_CLIP_EN.
module renderer_rect_sequencer #(
   parameter int MAX_X    = 639,
   parameter int MAX_LINE = 479
) (
   input  logic       i_master_clk,
   input  logic       i_reset,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   input  logic [9:0] i_cmd_x1,
   input  logic [9:0] i_cmd_x2,
   input  logic [9:0] i_cmd_y1,
   input  logic [9:0] i_cmd_y2,
   input  logic [3:0] i_cmd_color_red,
   input  logic [3:0] i_cmd_color_green,
   input  logic [3:0] i_cmd_color_blue,
   output logic       o_cmd_done,
   output logic       o_cmd_error,
   output logic       o_busy,
   output logic [9:0] o_fill_x1,
   output logic [9:0] o_fill_x2,
   output logic [9:0] o_fill_line,
   output logic [3:0] o_fill_color_red,
   output logic [3:0] o_fill_color_green,
   output logic [3:0] o_fill_color_blue,
   output logic       o_fill_start,
   input  logic       i_fill_done
);

   localparam logic [9:0] MAX_X_C    = 10'(MAX_X);
   localparam logic [9:0] MAX_LINE_C = 10'(MAX_LINE);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_START, S_WAIT, S_NEXT, S_FINISH
   } state_t;

   state_t     state, state_nxt;
   logic [9:0] y1_q, y2_q;
   logic       err_q;
   logic       reject;
   logic [9:0] x2_clip, y2_clip;

   // Rectangle validation on the latched command, with optional clamping of the far edges
   always_comb begin
      x2_clip = o_fill_x2;
      y2_clip = y2_q;
      reject  = (o_fill_x1 > o_fill_x2) || (y1_q > y2_q) ||
                (o_fill_x1 > MAX_X_C)   || (y1_q > MAX_LINE_C);
`ifdef RENDERER_RECT_SEQ_CLIP_EN
      if (o_fill_x2 > MAX_X_C)  x2_clip = MAX_X_C;
      if (y2_q > MAX_LINE_C)    y2_clip = MAX_LINE_C;
`else
      if ((o_fill_x2 > MAX_X_C) || (y2_q > MAX_LINE_C)) reject = 1'b1;
`endif
   end

   // State register
   always_ff @(posedge i_master_clk) begin
      if (i_reset) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic; fill_done only matters while waiting on the engine
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (i_cmd_valid) state_nxt = S_CHECK;
         S_CHECK:  state_nxt = reject ? S_FINISH : S_START;
         S_START:  state_nxt = S_WAIT;
         S_WAIT:   if (i_fill_done) state_nxt = S_NEXT;
         S_NEXT:   state_nxt = (o_fill_line == y2_q) ? S_FINISH : S_START;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Command latch, clipping write-back and line counter
   always_ff @(posedge i_master_clk) begin
      if (i_reset) begin
         o_fill_x1          <= '0;
         o_fill_x2          <= '0;
         o_fill_line        <= '0;
         o_fill_color_red   <= '0;
         o_fill_color_green <= '0;
         o_fill_color_blue  <= '0;
         y1_q               <= '0;
         y2_q               <= '0;
         err_q              <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_cmd_valid) begin
                  o_fill_x1          <= i_cmd_x1;
                  o_fill_x2          <= i_cmd_x2;
                  o_fill_color_red   <= i_cmd_color_red;
                  o_fill_color_green <= i_cmd_color_green;
                  o_fill_color_blue  <= i_cmd_color_blue;
                  y1_q               <= i_cmd_y1;
                  y2_q               <= i_cmd_y2;
               end
            end
            S_CHECK: begin
               err_q <= reject;
               if (!reject) begin
                  o_fill_line <= y1_q;
                  o_fill_x2   <= x2_clip;
                  y2_q        <= y2_clip;
               end
            end
            S_NEXT: begin
               // y2 never exceeds MAX_LINE here, so the increment cannot wrap
               if (o_fill_line != y2_q) o_fill_line <= o_fill_line + 10'd1;
            end
            default: ;
         endcase
      end
   end

   // Status and strobes are pure decodes of the registered state
   assign o_cmd_ready  = (state == S_IDLE);
   assign o_busy       = (state != S_IDLE);
   assign o_fill_start = (state == S_START);
   assign o_cmd_done   = (state == S_FINISH) && !err_q;
   assign o_cmd_error  = (state == S_FINISH) &&  err_q;

endmodule
